// File: rtl/riscv_csr_access_ctrl.sv
// riscv_csr_access_ctrl
//   Sequences one CSR instruction at a time (CSRRW/CSRRS/CSRRC, ECALL, MRET)
//   against a single-port CSR file with combinational read data, and returns
//   the old CSR value plus an optional PC redirect.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_op/addr/wdata/pc payload
//                         (op: 1=RW 2=RS 3=RC 4=ECALL 5=MRET, others illegal)
//   resp_valid/resp_ready response handshake; resp_rdata (old CSR value),
//                         resp_redirect/resp_target (PC redirect),
//                         resp_illegal (no CSR state changed)
//   csr_addr/csr_rdata    CSR file address and combinational read data
//   csr_we/csr_wdata      CSR file write strobe (one cycle per write) and data
module riscv_csr_access_ctrl #(
  parameter int unsigned                WORD_LENGTH = 32,
  parameter int unsigned                CSR_ADDR_W  = 12,
  parameter logic [CSR_ADDR_W-1:0]      MTVEC_ADDR  = 12'h305,
  parameter logic [CSR_ADDR_W-1:0]      MEPC_ADDR   = 12'h341,
  parameter logic [CSR_ADDR_W-1:0]      MCAUSE_ADDR = 12'h342,
  parameter int unsigned                ECALL_CAUSE = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [CSR_ADDR_W-1:0]  req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  logic [WORD_LENGTH-1:0] req_pc,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_redirect,
  output logic [WORD_LENGTH-1:0] resp_target,
  output logic                   resp_illegal,
  output logic [CSR_ADDR_W-1:0]  csr_addr,
  input  logic [WORD_LENGTH-1:0] csr_rdata,
  output logic                   csr_we,
  output logic [WORD_LENGTH-1:0] csr_wdata
);

  typedef enum logic [2:0] {
    OP_RW    = 3'd1,
    OP_RS    = 3'd2,
    OP_RC    = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_WR_EPC,
    S_WR_CAUSE,
    S_RD_TVEC,
    S_RD_EPC,
    S_RESP
  } state_t;

  state_t                 state, state_d;
  logic [2:0]             op_q;
  logic [CSR_ADDR_W-1:0]  addr_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  logic [WORD_LENGTH-1:0] pc_q;
  logic [WORD_LENGTH-1:0] new_q;

  logic accept;
  logic read_only;
  logic write_intended;
  logic legal_op;

  assign accept    = (state == S_IDLE) && req_valid;
  assign read_only = (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);
  // RS/RC with a zero mask only read; RW always writes.
  assign write_intended = (op_q == OP_RW) || (wdata_q != '0);
  assign legal_op = (req_op == OP_RW) || (req_op == OP_RS) || (req_op == OP_RC) ||
                    (req_op == OP_ECALL) || (req_op == OP_MRET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    csr_we     = 1'b0;
    csr_addr   = '0;
    csr_wdata  = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_RW, OP_RS, OP_RC: state_d = S_READ;
            OP_ECALL:            state_d = S_WR_EPC;
            OP_MRET:             state_d = S_RD_EPC;
            default:             state_d = S_RESP;
          endcase
        end
      end
      S_READ: begin
        csr_addr = addr_q;
        if (!write_intended || read_only) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        csr_we    = 1'b1;
        csr_addr  = addr_q;
        csr_wdata = new_q;
        state_d   = S_RESP;
      end
      S_WR_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = MEPC_ADDR;
        csr_wdata = pc_q;
        state_d   = S_WR_CAUSE;
      end
      S_WR_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = MCAUSE_ADDR;
        csr_wdata = WORD_LENGTH'(ECALL_CAUSE);
        state_d   = S_RD_TVEC;
      end
      S_RD_TVEC: begin
        csr_addr = MTVEC_ADDR;
        state_d  = S_RESP;
      end
      S_RD_EPC: begin
        csr_addr = MEPC_ADDR;
        state_d  = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response fields are cleared on accept and only updated before RESP,
  // so they hold steady for the whole response phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      pc_q          <= '0;
      new_q         <= '0;
      resp_rdata    <= '0;
      resp_redirect <= 1'b0;
      resp_target   <= '0;
      resp_illegal  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q          <= req_op;
            addr_q        <= req_addr;
            wdata_q       <= req_wdata;
            pc_q          <= req_pc;
            resp_rdata    <= '0;
            resp_redirect <= 1'b0;
            resp_target   <= '0;
            resp_illegal  <= !legal_op;
          end
        end
        S_READ: begin
          resp_rdata   <= csr_rdata;
          resp_illegal <= read_only && write_intended;
          case (op_q)
            OP_RS:   new_q <= csr_rdata | wdata_q;
            OP_RC:   new_q <= csr_rdata & ~wdata_q;
            default: new_q <= wdata_q;
          endcase
        end
        S_RD_TVEC: begin
          resp_target   <= {csr_rdata[WORD_LENGTH-1:2], 2'b00};
          resp_redirect <= 1'b1;
        end
        S_RD_EPC: begin
          resp_target   <= csr_rdata;
          resp_redirect <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_csr_access_ctrl.sv
// Testbench for riscv_csr_access_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level CSR model.
module tb_riscv_csr_access_ctrl;

  localparam logic [11:0] MTVEC  = 12'h305;
  localparam logic [11:0] MEPC   = 12'h341;
  localparam logic [11:0] MCAUSE = 12'h342;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata, req_pc;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_target;
  logic        resp_illegal;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wdata;

  always #5 clk = ~clk;

  riscv_csr_access_ctrl #(
    .WORD_LENGTH(32),
    .CSR_ADDR_W (12),
    .MTVEC_ADDR (12'h305),
    .MEPC_ADDR  (12'h341),
    .MCAUSE_ADDR(12'h342),
    .ECALL_CAUSE(11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_pc       (req_pc),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_redirect(resp_redirect),
    .resp_target  (resp_target),
    .resp_illegal (resp_illegal),
    .csr_addr     (csr_addr),
    .csr_rdata    (csr_rdata),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata)
  );

  // CSR file seen by the DUT, and the reference copy the model maintains.
  logic [31:0] mem  [0:4095] = '{default: '0};
  logic [31:0] refm [0:4095] = '{default: '0};
  int unsigned we_cnt = 0;
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign csr_rdata = mem[csr_addr];

  always @(posedge clk) begin
    if (csr_we) begin
      mem[csr_addr] <= csr_wdata;
      we_cnt        <= we_cnt + 1;
    end
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    refm[a] = d;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input int unsigned dly);
    logic [31:0] e_rdata = '0, e_target = '0, old;
    logic        e_redir = 1'b0, e_ill = 1'b0;
    int unsigned e_lat = 1, e_we = 0, we0, n;

    // Reference: architectural effect of one CSR instruction.
    case (op)
      3'd1, 3'd2, 3'd3: begin
        old     = refm[addr];
        e_rdata = old;
        if (op != 3'd1 && wd == 0) begin
          e_lat = 2;
        end else if (addr[11:10] == 2'b11) begin
          e_ill = 1'b1;
          e_lat = 2;
        end else begin
          if (op == 3'd1)      refm[addr] = wd;
          else if (op == 3'd2) refm[addr] = old | wd;
          else                 refm[addr] = old & ~wd;
          e_lat = 3;
          e_we  = 1;
        end
      end
      3'd4: begin
        refm[MEPC]   = pc;
        refm[MCAUSE] = 32'd11;
        e_target     = (refm[MTVEC] / 4) * 4;
        e_redir      = 1'b1;
        e_lat        = 4;
        e_we         = 2;
      end
      3'd5: begin
        e_target = refm[MEPC];
        e_redir  = 1'b1;
        e_lat    = 2;
      end
      default: begin
        e_ill = 1'b1;
        e_lat = 1;
      end
    endcase

    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    req_pc     = pc;
    resp_ready = (dly == 0);
    we0        = we_cnt;
    @(posedge clk); #1;
    // Junk on the request channel while busy must be ignored.
    req_valid = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = $urandom;
    req_pc    = $urandom;
    n = 1;
    while (!resp_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, e_lat);
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    chk("rdata", resp_rdata, e_rdata);
    chk("redirect", {31'b0, resp_redirect}, {31'b0, e_redir});
    chk("target", resp_target, e_target);
    chk("illegal", {31'b0, resp_illegal}, {31'b0, e_ill});
    for (int unsigned i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_target", resp_target, e_target);
      chk("hold_rdata", resp_rdata, e_rdata);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    chk("resp_done", {31'b0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("we_pulses", we_cnt - we0, e_we);
    if (op >= 3'd1 && op <= 3'd3) chk("csr_value", mem[addr], refm[addr]);
    if (op == 3'd4) begin
      chk("mepc", mem[MEPC], refm[MEPC]);
      chk("mcause", mem[MCAUSE], refm[MCAUSE]);
    end
  endtask

  logic [11:0] pool [10] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340,
                             12'hC00, 12'hC01, 12'hF11, 12'h7C0, 12'hB00};

  initial begin
    logic [2:0]  op;
    int unsigned r;
    logic [31:0] wd;

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
    req_wdata = '0; req_pc = '0; resp_ready = 1'b0;
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_csr_we", {31'b0, csr_we}, 32'd0);
    chk("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_target", resp_target, 32'd0);
    chk("rst_flags", {30'b0, resp_redirect, resp_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    preload(12'h305, 32'h0);
    run_txn(3'd1, 12'h305, 32'h8000_0100, 32'h0, 0);
    chk("rw_written", mem[12'h305], 32'h8000_0100);
    preload(12'h300, 32'h0000_0008);
    run_txn(3'd2, 12'h300, 32'h0000_0080, 32'h0, 1);
    chk("rs_written", mem[12'h300], 32'h0000_0088);
    run_txn(3'd3, 12'h300, 32'h0, 32'h0, 0);
    run_txn(3'd1, 12'hC00, 32'h1234_5678, 32'h0, 0);
    run_txn(3'd7, 12'h300, 32'hFFFF_FFFF, 32'h0, 0);
    preload(MTVEC, 32'h0000_0203);
    run_txn(3'd4, 12'h0, 32'h0, 32'h0000_0040, 0);
    chk("ecall_mepc", mem[MEPC], 32'h0000_0040);
    preload(MEPC, 32'h0000_0044);
    run_txn(3'd5, 12'h0, 32'h0, 32'h0, 5);

    // Reset in the middle of an ECALL trap sequence
    preload(MCAUSE, 32'h0000_1234);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_pc = 32'h0000_0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_we_cause", {31'b0, csr_we}, 32'd1);
    chk("mid_addr_cause", {20'b0, csr_addr}, {20'b0, MCAUSE});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, csr_we}, 32'd0);
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_mcause", mem[MCAUSE], 32'h0000_1234);
    chk("mid_mepc", mem[MEPC], 32'h0000_0080);
    refm[MEPC] = 32'h0000_0080;

    // Randomized transactions
    for (int unsigned i = 0; i < 10; i++) preload(pool[i], $urandom);
    for (int unsigned t = 0; t < 250; t++) begin
      r = $urandom_range(0, 15);
      if (r < 4)       op = 3'd1;
      else if (r < 7)  op = 3'd2;
      else if (r < 10) op = 3'd3;
      else if (r < 12) op = 3'd4;
      else if (r < 14) op = 3'd5;
      else begin
        r = $urandom_range(0, 2);
        op = (r == 0) ? 3'd0 : (r == 1) ? 3'd6 : 3'd7;
      end
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_txn(op, pool[$urandom_range(0, 9)], wd, $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_csr_access_ctrl.md
Name: riscv_csr_access_ctrl

Overview:
- Sequencer between the execute stage and the CSR register file.
- Accepts one CSR instruction at a time over a valid/ready request channel: CSRRW/CSRRS/CSRRC, ECALL or MRET.
- Runs the read/modify/write (or trap) sequence against the file's single-port, combinational-read interface.
- Returns the old CSR value, plus a PC redirect for traps, over a valid/ready response channel.

Parameters:
- WORD_LENGTH, 32, data/PC width
- CSR_ADDR_W, 12, CSR address width
- MTVEC_ADDR, 12'h305, trap vector CSR
- MEPC_ADDR, 12'h341, exception PC CSR
- MCAUSE_ADDR, 12'h342, cause CSR
- ECALL_CAUSE, 11, mcause value for ECALL from M-mode

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  3  1=RW, 2=RS, 3=RC, 4=ECALL, 5=MRET; all other values are illegal
- req_addr  in  CSR_ADDR_W  target CSR
- req_wdata  in  WORD_LENGTH  rs1 value or zero-extended immediate
- req_pc  in  WORD_LENGTH  PC of the instruction
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  WORD_LENGTH  old CSR value (rd writeback)
- resp_redirect  out  1  PC must be redirected to resp_target
- resp_target  out  WORD_LENGTH  redirect target
- resp_illegal  out  1  illegal instruction; no CSR state was changed
- csr_addr  out  CSR_ADDR_W  CSR file address
- csr_rdata  in  WORD_LENGTH  CSR file combinational read data for csr_addr
- csr_we  out  1  CSR file write enable, sampled on rising clk
- csr_wdata  out  WORD_LENGTH  CSR file write data

Behaviour:
- Reset values (asynchronous on rst_n low): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_redirect=0; resp_target=0; resp_illegal=0; csr_we=0; csr_addr=0; csr_wdata=0.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready at a rising edge; op, addr, wdata and pc are latched into internal registers.
- csr_we is asserted for exactly one cycle per write; it is never asserted outside the WRITE, WR_EPC and WR_CAUSE states.
- States and transitions:
  - IDLE -> READ for RW/RS/RC.
  - IDLE -> WR_EPC for ECALL.
  - IDLE -> RD_EPC for MRET.
  - IDLE -> RESP for an illegal op, with resp_illegal=1.
  - READ: csr_addr=latched addr; capture csr_rdata into old value. Compute new value: RW=wdata; RS=old|wdata; RC=old&~wdata.
  - READ next state:
    - Read-only CSR (addr[11:10]==2'b11) with a write intended -> RESP, illegal=1, no write.
    - RS/RC with wdata==0 -> RESP, no write.
    - Otherwise -> WRITE.
  - WRITE: csr_we=1, csr_addr=addr, csr_wdata=new value -> RESP.
  - WR_EPC: write MEPC_ADDR<=pc -> WR_CAUSE.
  - WR_CAUSE: write MCAUSE_ADDR<=ECALL_CAUSE -> RD_TVEC.
  - RD_TVEC: csr_addr=MTVEC_ADDR; target={csr_rdata[31:2],2'b00}; redirect=1 -> RESP.
  - RD_EPC: csr_addr=MEPC_ADDR; target=csr_rdata; redirect=1 -> RESP.
  - RESP: resp_valid=1. All resp_* outputs are stable until resp_valid && resp_ready, then -> IDLE with resp_valid=0.
- ECALL and MRET return resp_rdata=0.
- RW to a read-only CSR is illegal even though it also reads.
- Latency from accept to resp_valid:
  - RW with write: 3 cycles.
  - RS/RC with no write: 2 cycles.
  - ECALL: 4 cycles.
  - MRET: 2 cycles.
  - Illegal op: 1 cycle.
- resp_ready may be held high permanently; the response then completes in its first RESP cycle, and the next request is accepted no earlier than the following cycle.
- req_* inputs are ignored outside IDLE.
- rst_n asserted in any state: return to IDLE immediately; csr_we drops asynchronously; any partial trap sequence is abandoned (e.g. MEPC written, MCAUSE not).

Test Plan:
- Reset mid-sequence: assert rst_n low during WR_CAUSE of an ECALL -> csr_we=0 immediately; resp_valid=0; req_ready=1 after release; MCAUSE unchanged.
- CSRRW addr=0x305, wdata=0x8000_0100, old 0x0 -> one csr_we pulse writing 0x8000_0100; resp_rdata=0x0; resp_valid 3 cycles after accept.
- CSRRS addr=0x300, old 0x0000_0008, wdata=0x0000_0080 -> csr_wdata=0x0000_0088, resp_rdata=0x8. Then CSRRC with wdata=0 -> no csr_we pulse; resp_rdata=0x88.
- CSRRW addr=0xC00 (read-only) -> resp_illegal=1; no csr_we pulse. req_op=7 -> resp_illegal=1 after 1 cycle.
- ECALL pc=0x0000_0040, mtvec=0x0000_0203 -> writes MEPC=0x40, then MCAUSE=11; resp_redirect=1, resp_target=0x0000_0200.
- MRET with MEPC=0x44 and resp_ready held low 5 cycles -> resp_target=0x44 held stable throughout; req_ready=0 until the handshake completes.
